// File: rtl/pipeline_ctrl_pkg.sv
// Shared update codes and controller state encoding for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

  localparam logic [1:0] UPD_HOLD  = 2'b00;
  localparam logic [1:0] UPD_ADV   = 2'b01;
  localparam logic [1:0] UPD_FLUSH = 2'b10;

  typedef enum logic [1:0] {
    PC_RUN  = 2'd0,
    PC_WAIT = 2'd1,
    PC_HALT = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use match: a D-stage source that depends on the E-stage load's destination.
module pipeline_ctrl_load_use_detect (
  input  logic [6:0] d_rs,
  input  logic [6:0] d_rt,
  input  logic       d_use_s,
  input  logic       d_use_t,
  input  logic [1:0] de_rw,
  input  logic [5:0] de_rd,
  input  logic       de_is_load,
  output logic       hazard_c
);

  logic rs_hit;
  logic rt_hit;

  // bit6 of a source selects the register file, matched against de_rw[1]
  assign rs_hit = d_use_s && (de_rw[1] == d_rs[6]) && (de_rd == d_rs[5:0]);
  assign rt_hit = d_use_t && (de_rw[1] == d_rt[6]) && (de_rd == d_rt[5:0]);

  assign hazard_c = de_is_load && (de_rw != 2'b00) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller driving F/D, D/E, E/W update codes and PC enable/redirect.
// Optional perf counters (stall_cycles, flush_cycles) with `define PIPE_CTRL_PERF_EN.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_W = 5
`ifdef PIPE_CTRL_PERF_EN
  , parameter int unsigned PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        d_rs,
  input  logic [6:0]        d_rt,
  input  logic              d_use_s,
  input  logic              d_use_t,
  input  logic [1:0]        de_rw,
  input  logic [5:0]        de_rd,
  input  logic              de_is_load,
  input  logic [WAIT_W-1:0] de_wait_time,
  input  logic              de_stop,
  input  logic              e_redirect,
  input  logic              mem_busy,
  output logic [1:0]        fd_update,
  output logic [1:0]        de_update,
  output logic [1:0]        ew_update,
  output logic              pc_en,
  output logic              pc_redirect,
  output logic              halted
`ifdef PIPE_CTRL_PERF_EN
  , output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_cycles
`endif
);

  pctrl_state_t      state;
  pctrl_state_t      state_nxt;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_nxt;
  logic              load_use_c;

  pipeline_ctrl_load_use_detect u_load_use_detect (
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_use_s    (d_use_s),
    .d_use_t    (d_use_t),
    .de_rw      (de_rw),
    .de_rd      (de_rd),
    .de_is_load (de_is_load),
    .hazard_c   (load_use_c)
  );

  // State register and wait counter
  always_ff @(posedge clk) begin
    state <= state_nxt;
    cnt   <= cnt_nxt;
  end

  // Next-state and update-code generation
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    fd_update   = UPD_ADV;
    de_update   = UPD_ADV;
    ew_update   = UPD_ADV;
    pc_en       = 1'b1;
    pc_redirect = 1'b0;
    halted      = 1'b0;

    if (rst) begin
      state_nxt = PC_RUN;
      cnt_nxt   = '0;
      fd_update = UPD_FLUSH;
      de_update = UPD_FLUSH;
      ew_update = UPD_FLUSH;
      pc_en     = 1'b0;
    end else begin
      case (state)
        PC_HALT: begin
          fd_update = UPD_HOLD;
          de_update = UPD_HOLD;
          ew_update = UPD_HOLD;
          pc_en     = 1'b0;
          halted    = 1'b1;
        end
        PC_RUN, PC_WAIT: begin
          if (mem_busy) begin
            fd_update = UPD_HOLD;
            de_update = UPD_HOLD;
            ew_update = UPD_HOLD;
            pc_en     = 1'b0;
          end else if ((state == PC_RUN && de_wait_time != '0) ||
                       (state == PC_WAIT && cnt != WAIT_W'(1))) begin
            // E holds its instruction; E/W receives a bubble each stalled cycle
            fd_update = UPD_HOLD;
            de_update = UPD_HOLD;
            ew_update = UPD_FLUSH;
            pc_en     = 1'b0;
            state_nxt = PC_WAIT;
            cnt_nxt   = (state == PC_RUN) ? de_wait_time : cnt - WAIT_W'(1);
          end else begin
            // E-stage instruction advances: redirect, stop and load-use apply here only
            cnt_nxt   = '0;
            state_nxt = de_stop ? PC_HALT : PC_RUN;
            if (e_redirect) begin
              fd_update   = UPD_FLUSH;
              de_update   = UPD_FLUSH;
              pc_redirect = 1'b1;
            end else if (load_use_c) begin
              fd_update = UPD_HOLD;
              de_update = UPD_FLUSH;
              pc_en     = 1'b0;
            end
          end
        end
        default: begin
          state_nxt = PC_RUN;
          cnt_nxt   = '0;
          fd_update = UPD_HOLD;
          de_update = UPD_HOLD;
          ew_update = UPD_HOLD;
          pc_en     = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Stall counts cycles with the PC frozen outside reset/HALT; flush counts redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!pc_en && state != PC_HALT) stall_cycles <= stall_cycles + PERF_W'(1);
      if (pc_redirect)                flush_cycles <= flush_cycles + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected outputs, a monitor checks them.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] d_rs, d_rt;
  logic       d_use_s, d_use_t;
  logic [1:0] de_rw;
  logic [5:0] de_rd;
  logic       de_is_load;
  logic [4:0] de_wait_time;
  logic       de_stop, e_redirect, mem_busy;
  logic [1:0] fd_update, de_update, ew_update;
  logic       pc_en, pc_redirect, halted;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .d_rs         (d_rs),
    .d_rt         (d_rt),
    .d_use_s      (d_use_s),
    .d_use_t      (d_use_t),
    .de_rw        (de_rw),
    .de_rd        (de_rd),
    .de_is_load   (de_is_load),
    .de_wait_time (de_wait_time),
    .de_stop      (de_stop),
    .e_redirect   (e_redirect),
    .mem_busy     (mem_busy),
    .fd_update    (fd_update),
    .de_update    (de_update),
    .ew_update    (ew_update),
    .pc_en        (pc_en),
    .pc_redirect  (pc_redirect),
    .halted       (halted)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [8:0] vec;   // {fd, de, ew, pc_en, pc_redirect, halted}
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Expected codes as {fd, de, ew}
  localparam logic [5:0] C_RST  = 6'b10_10_10;
  localparam logic [5:0] C_ADV  = 6'b01_01_01;
  localparam logic [5:0] C_HOLD = 6'b00_00_00;
  localparam logic [5:0] C_MC   = 6'b00_00_10;
  localparam logic [5:0] C_LU   = 6'b00_10_01;
  localparam logic [5:0] C_RDR  = 6'b10_10_01;

  // Push this cycle's expectation, then move to just after the next rising edge
  task automatic chk(input string name, input logic [5:0] codes,
                     input logic pe, input logic pr, input logic h);
    exp_t e;
    e.name = name;
    e.vec  = {codes, pe, pr, h};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; d_rs = 7'h00; d_rt = 7'h00; d_use_s = 1'b0; d_use_t = 1'b0;
    de_rw = 2'b00; de_rd = 6'd0; de_is_load = 1'b0; de_wait_time = 5'd0;
    de_stop = 1'b0; e_redirect = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_load_use();
    de_is_load = 1'b1; de_rw = 2'b01; de_rd = 6'd5; d_rs = 7'h05; d_use_s = 1'b1;
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {fd_update, de_update, ew_update, pc_en, pc_redirect, halted};
      n_vec++;
      if (act !== e.vec) begin
        n_bad++;
        $display("FAIL %s: got fd/de/ew/pe/pr/h=%b required %b", e.name, act, e.vec);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset and normal flow
    rst = 1'b1;
    chk("rst_0", C_RST, 1'b0, 1'b0, 1'b0);
    chk("rst_1", C_RST, 1'b0, 1'b0, 1'b0);
    idle();
    chk("run_idle", C_ADV, 1'b1, 1'b0, 1'b0);

    // Multi-cycle W=3: residency 4, de_wait_time ignored while waiting
    de_wait_time = 5'd3;
    chk("mc3_c1", C_MC, 1'b0, 1'b0, 1'b0);
    chk("mc3_c2", C_MC, 1'b0, 1'b0, 1'b0);
    chk("mc3_c3", C_MC, 1'b0, 1'b0, 1'b0);
    chk("mc3_adv", C_ADV, 1'b1, 1'b0, 1'b0);
    de_wait_time = 5'd0;
    chk("mc3_after", C_ADV, 1'b1, 1'b0, 1'b0);

    // Load-use hazard variants
    set_load_use();
    chk("lu_rs", C_LU, 1'b0, 1'b0, 1'b0);
    idle();
    chk("lu_resolved", C_ADV, 1'b1, 1'b0, 1'b0);
    set_load_use(); d_rs = 7'h45;
    chk("lu_filesel_mismatch", C_ADV, 1'b1, 1'b0, 1'b0);
    set_load_use(); d_use_s = 1'b0;
    chk("lu_rs_unused", C_ADV, 1'b1, 1'b0, 1'b0);
    set_load_use(); d_rs = 7'h03; d_rt = 7'h05; d_use_t = 1'b1;
    chk("lu_rt", C_LU, 1'b0, 1'b0, 1'b0);
    set_load_use(); de_rw = 2'b00;
    chk("lu_no_write", C_ADV, 1'b1, 1'b0, 1'b0);
    set_load_use(); de_rw = 2'b11; d_rs = 7'h45;
    chk("lu_file1", C_LU, 1'b0, 1'b0, 1'b0);
    set_load_use(); de_is_load = 1'b0;
    chk("lu_not_load", C_ADV, 1'b1, 1'b0, 1'b0);

    // Redirect beats load-use
    set_load_use(); e_redirect = 1'b1;
    chk("redirect_over_lu", C_RDR, 1'b1, 1'b1, 1'b0);
    idle();

    // Redirect ignored until the multi-cycle op advances
    de_wait_time = 5'd1; e_redirect = 1'b1;
    chk("mc1_redirect_stall", C_MC, 1'b0, 1'b0, 1'b0);
    chk("mc1_redirect_adv", C_RDR, 1'b1, 1'b1, 1'b0);
    idle();
    chk("post_redirect", C_ADV, 1'b1, 1'b0, 1'b0);

    // W=2 with 3 cycles of mem_busy mid-WAIT: residency 6
    de_wait_time = 5'd2;
    chk("mb_c1", C_MC, 1'b0, 1'b0, 1'b0);
    mem_busy = 1'b1;
    chk("mb_busy1", C_HOLD, 1'b0, 1'b0, 1'b0);
    chk("mb_busy2", C_HOLD, 1'b0, 1'b0, 1'b0);
    chk("mb_busy3", C_HOLD, 1'b0, 1'b0, 1'b0);
    mem_busy = 1'b0;
    chk("mb_c2", C_MC, 1'b0, 1'b0, 1'b0);
    chk("mb_adv", C_ADV, 1'b1, 1'b0, 1'b0);
    idle();
    mem_busy = 1'b1; e_redirect = 1'b1;
    chk("mb_over_redirect", C_HOLD, 1'b0, 1'b0, 1'b0);
    idle();

    // Reset mid-WAIT drops the pending stall
    de_wait_time = 5'd5;
    chk("rstw_c1", C_MC, 1'b0, 1'b0, 1'b0);
    chk("rstw_c2", C_MC, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    chk("rstw_rst", C_RST, 1'b0, 1'b0, 1'b0);
    idle();
    chk("rstw_run", C_ADV, 1'b1, 1'b0, 1'b0);

    // Stop on the non-advancing cycle of a multi-cycle op is ignored
    de_wait_time = 5'd1; de_stop = 1'b1;
    chk("stopw_stall", C_MC, 1'b0, 1'b0, 1'b0);
    chk("stopw_adv", C_ADV, 1'b1, 1'b0, 1'b0);
    idle();
    chk("stopw_halted", C_HOLD, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    chk("stopw_rst", C_RST, 1'b0, 1'b0, 1'b0);
    idle();
    chk("stopw_run", C_ADV, 1'b1, 1'b0, 1'b0);

    // Stop in RUN, then HALT held 20 cycles regardless of inputs
    de_stop = 1'b1;
    chk("stop_adv", C_ADV, 1'b1, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 20; i++) begin
      e_redirect   = (i == 3);
      mem_busy     = (i == 7);
      de_wait_time = (i == 11) ? 5'd4 : 5'd0;
      if (i == 15) set_load_use();
      chk($sformatf("halt_%0d", i), C_HOLD, 1'b0, 1'b0, 1'b1);
      idle();
    end
    rst = 1'b1;
    chk("halt_rst", C_RST, 1'b0, 1'b0, 1'b0);
    idle();
    chk("halt_exit_run", C_ADV, 1'b1, 1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
